// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus WIDTH-cycle MUL/DIV/MOD.
// The iterative MUL/DIV/MOD datapath is present only when ALU_MULDIV_EN is defined.
module multicycle_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             div_zero
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ITER = 1'b1;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_LSR = 5'd2;
  localparam logic [4:0] OP_LSL = 5'd3;
  localparam logic [4:0] OP_ROR = 5'd4;
  localparam logic [4:0] OP_ROL = 5'd5;
  localparam logic [4:0] OP_AND = 5'd9;
  localparam logic [4:0] OP_OR  = 5'd10;
  localparam logic [4:0] OP_XOR = 5'd11;
  localparam logic [4:0] OP_CMP = 5'd12;
  localparam logic [4:0] OP_NOT = 5'd13;
  localparam logic [4:0] OP_INC = 5'd14;
  localparam logic [4:0] OP_DEC = 5'd15;

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] LP_W     = WIDTH'(WIDTH);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_div_zero;

  logic             w_accept;
  logic             w_is_iter;
  logic [WIDTH-1:0] w_fin_val;
  logic             w_fin_c;
  logic [3:0]       w_fin_flags;

  logic [WIDTH-1:0] w_arith_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [WIDTH:0]   w_lsr_ext;
  logic [WIDTH:0]   w_lsl_ext;
  logic [WIDTH-1:0] w_rot_amt;
  logic [WIDTH-1:0] w_val;
  logic             w_c;
  logic             w_v;
  logic             w_wr;
  logic             w_nop;
  logic             w_dz;
  logic [3:0]       w_sc_flags;

  assign busy     = (r_state == S_ITER);
  assign done     = r_done;
  assign result   = r_result;
  assign flags    = r_flags;
  assign div_zero = r_div_zero;

  assign w_accept = (r_state == S_IDLE) && start;

  // INC/DEC reuse the ADD/SUB paths with a constant second operand
  assign w_arith_b = (opcode == OP_INC || opcode == OP_DEC) ? WIDTH'(1) : b;
  assign w_sum     = {1'b0, a} + {1'b0, w_arith_b};
  assign w_diff    = {1'b0, a} - {1'b0, w_arith_b};
  assign w_add_ovf = (a[WIDTH-1] == w_arith_b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
  assign w_sub_ovf = (a[WIDTH-1] != w_arith_b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

  // One guard bit beside the operand captures the last bit shifted out
  assign w_lsr_ext = {a, 1'b0} >> b;
  assign w_lsl_ext = {1'b0, a} << b;
  assign w_rot_amt = b % LP_W;

  always_comb begin
    w_val = r_result;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_wr  = 1'b1;
    w_nop = 1'b0;
    w_dz  = 1'b0;
    case (opcode)
      OP_ADD, OP_INC: begin
        w_val = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_add_ovf;
      end
      OP_SUB, OP_DEC, OP_CMP: begin
        w_val = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = w_sub_ovf;
        w_wr  = (opcode != OP_CMP);
      end
      OP_LSR: begin
        w_val = w_lsr_ext[WIDTH:1];
        w_c   = w_lsr_ext[0];
      end
      OP_LSL: begin
        w_val = w_lsl_ext[WIDTH-1:0];
        w_c   = w_lsl_ext[WIDTH];
      end
      OP_ROR: w_val = (a >> w_rot_amt) | (a << (LP_W - w_rot_amt));
      OP_ROL: w_val = (a << w_rot_amt) | (a >> (LP_W - w_rot_amt));
      OP_AND: w_val = a & b;
      OP_OR:  w_val = a | b;
      OP_XOR: w_val = a ^ b;
      OP_NOT: w_val = ~a;
`ifdef ALU_MULDIV_EN
      // Only reached with b == 0; nonzero divisors take the iterative path
      5'd7: begin
        w_val = '1;
        w_dz  = 1'b1;
      end
      5'd8: begin
        w_val = a;
        w_dz  = 1'b1;
      end
`endif
      default: begin
        w_wr  = 1'b0;
        w_nop = 1'b1;
      end
    endcase
  end

  assign w_sc_flags  = w_nop ? 4'b0000 : {(w_val == '0), w_val[WIDTH-1], w_c, w_v};
  assign w_fin_flags = {(w_fin_val == '0), w_fin_val[WIDTH-1], w_fin_c, 1'b0};

`ifdef ALU_MULDIV_EN
  localparam logic [4:0] OP_MUL = 5'd6;
  localparam logic [4:0] OP_DIV = 5'd7;
  localparam logic [4:0] OP_MOD = 5'd8;
  localparam logic [1:0] K_MUL  = 2'd0;
  localparam logic [1:0] K_DIV  = 2'd1;
  localparam logic [1:0] K_MOD  = 2'd2;

  // r_hi: product high half / partial remainder; r_lo: multiplier / quotient
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic [1:0]       r_kind;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;

  assign w_is_iter = (opcode == OP_MUL) ||
                     ((opcode == OP_DIV || opcode == OP_MOD) && (b != '0));

  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_opnd};
    w_hi_next   = r_hi;
    w_lo_next   = r_lo;
    if (r_kind == K_MUL) begin
      w_hi_next = w_mul_sum[WIDTH:1];
      w_lo_next = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end else if (!w_div_diff[WIDTH]) begin
      w_hi_next = w_div_diff[WIDTH-1:0];
      w_lo_next = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_hi_next = w_div_shift[WIDTH-1:0];
      w_lo_next = {r_lo[WIDTH-2:0], 1'b0};
    end
  end

  assign w_fin_val = (r_kind == K_MOD) ? w_hi_next : w_lo_next;
  assign w_fin_c   = (r_kind == K_MUL) && (w_hi_next != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
      r_kind <= K_MUL;
    end else if (w_accept && w_is_iter) begin
      r_hi   <= '0;
      r_lo   <= a;
      r_opnd <= b;
      r_kind <= (opcode == OP_MUL) ? K_MUL : ((opcode == OP_DIV) ? K_DIV : K_MOD);
    end else if (r_state == S_ITER) begin
      r_hi <= w_hi_next;
      r_lo <= w_lo_next;
    end
  end
`else
  assign w_is_iter = 1'b0;
  assign w_fin_val = r_result;
  assign w_fin_c   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_flags    <= 4'b0000;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_iter) begin
              r_state <= S_ITER;
              r_cnt   <= '0;
            end else begin
              if (w_wr) r_result <= w_val;
              r_flags    <= w_sc_flags;
              r_div_zero <= w_dz;
              r_done     <= 1'b1;
            end
          end
        end
        default: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_result   <= w_fin_val;
            r_flags    <= w_fin_flags;
            r_div_zero <= 1'b0;
            r_done     <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH = 16) against an arithmetic reference model.
// Expectations follow ALU_MULDIV_EN the same way the design does.
`timescale 1ns/1ps
module tb_multicycle_alu;
  localparam int     W = 16;
  localparam longint M = 64'd1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [4:0]   opcode;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         div_zero;

  int     tests = 0;
  int     fails = 0;
  longint m_result;
  bit     m_dz;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .a(a_in), .b(b_in),
    .busy(busy), .done(done), .result(result), .flags(flags), .div_zero(div_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation definitions
  task automatic model(input int op, input longint ua, input longint ub, input longint old_res,
                       output longint res, output logic [3:0] fl, output bit dz, output int lat);
    longint val, sa, sb, s, r;
    bit c, v, wr, nop;
    val = 0; c = 0; v = 0; wr = 1; nop = 0; dz = 0; lat = 0;
    if (op == 14 || op == 15) ub = 1;
    sa = (ua >= M / 2) ? ua - M : ua;
    sb = (ub >= M / 2) ? ub - M : ub;
    case (op)
      0, 14: begin
        val = (ua + ub) % M; c = (ua + ub) >= M;
        s = sa + sb; v = (s > M / 2 - 1) || (s < -(M / 2));
      end
      1, 12, 15: begin
        val = (ua - ub + M) % M; c = ua < ub;
        s = sa - sb; v = (s > M / 2 - 1) || (s < -(M / 2));
        wr = (op != 12);
      end
      2: if (ub == 0) val = ua;
         else if (ub <= W) begin val = ua >> ub; c = ((ua >> (ub - 1)) & 1) != 0; end
      3: if (ub == 0) val = ua;
         else if (ub <= W) begin val = (ua << ub) % M; c = ((ua >> (W - ub)) & 1) != 0; end
      4: begin r = ub % W; val = ((ua >> r) | (ua << (W - r))) % M; end
      5: begin r = ub % W; val = ((ua << r) | (ua >> (W - r))) % M; end
`ifdef ALU_MULDIV_EN
      6: begin val = (ua * ub) % M; c = (ua * ub) >= M; lat = W; end
      7: if (ub == 0) begin val = M - 1; dz = 1; end else begin val = ua / ub; lat = W; end
      8: if (ub == 0) begin val = ua; dz = 1; end else begin val = ua % ub; lat = W; end
`endif
      9:  val = ua & ub;
      10: val = ua | ub;
      11: val = ua ^ ub;
      13: val = (M - 1) - ua;
      default: begin nop = 1; wr = 0; end
    endcase
    fl  = nop ? 4'b0000 : {val == 0, val >= M / 2, c, v};
    res = wr ? val : old_res;
  endtask

  // Called at a negedge; returns at the negedge where done is seen, so chained calls are back-to-back
  task automatic run_op(input int op, input logic [W-1:0] av, input logic [W-1:0] bv, input bit inject);
    longint er;
    logic [3:0] ef;
    bit edz;
    int el, e, bcnt;
    string tag;
    model(op, av, bv, m_result, er, ef, edz, el);
    tag = $sformatf("op=%0d a=%h b=%h", op, av, bv);
    opcode = 5'(op); a_in = av; b_in = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_in = W'($urandom); b_in = W'($urandom);
    e = 0; bcnt = 0;
    while (1) begin
      @(negedge clk);
      if (done || e > 40) break;
      if (busy) bcnt++;
      e++;
      if (inject && e == 3) begin start = 1'b1; opcode = 5'd0; end
      if (inject && e == 5) start = 1'b0;
    end
    check({tag, " latency"}, 64'(e), 64'(el));
    check({tag, " busy_cycles"}, 64'(bcnt), 64'((el == 0) ? 0 : W));
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " result"}, 64'(result), 64'(er));
    check({tag, " flags"}, 64'(flags), 64'(ef));
    check({tag, " div_zero"}, 64'(div_zero), 64'(edz));
    $display("[TB] op=%0d a=%h b=%h -> result=%h flags=%b div_zero=%b latency=%0d",
             op, av, bv, result, flags, div_zero, e);
    m_result = er;
    m_dz = edz;
  endtask

  initial begin
    int bvals[7] = '{0, 1, 7, 15, 16, 17, 31};
    int op;
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; opcode = '0; a_in = '0; b_in = '0;
    m_result = 0; m_dz = 0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset flags", 64'(flags), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 16'h7FFF, 16'h0001, 0);
    check("add overflow result", 64'(result), 64'h8000);
    check("add overflow flags", 64'(flags), 64'b0101);
    run_op(12, 16'd5, 16'd9, 0);
    check("cmp flags", 64'(flags), 64'b0110);
    run_op(6, 16'd300, 16'd300, 1);
    run_op(7, 16'd100, 16'd7, 0);
    run_op(8, 16'd100, 16'd7, 0);
    run_op(7, 16'd5, 16'd0, 0);
    run_op(8, 16'd5, 16'd0, 0);
    run_op(9, 16'hF0F0, 16'h0FF0, 0);
    run_op(20, 16'h1234, 16'h5678, 0);
    run_op(14, 16'hFFFF, 16'h0000, 0);
    run_op(15, 16'h0000, 16'h0000, 0);
    run_op(15, 16'h8000, 16'h0000, 0);
    run_op(13, 16'hFFFF, 16'h0000, 0);

    for (int s = 2; s <= 5; s++)
      for (int i = 0; i < 7; i++)
        run_op(s, 16'hA5C3, W'(bvals[i]), 0);

    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 31);
      ra = W'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      run_op(op, ra, rb, ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of a multiply
    opcode = 5'd6; a_in = 16'd300; b_in = 16'd300; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset result", 64'(result), 64'd0);
    check("midreset flags", 64'(flags), 64'd0);
    check("midreset div_zero", 64'(div_zero), 64'd0);
    rst = 1'b0;
    m_result = 0; m_dz = 0;
    run_op(0, 16'd2, 16'd3, 0);
    repeat (2) @(negedge clk);
    check("done single pulse", 64'(done), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
